// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port architectural register file.
// ABI register indices, default sizing and packed-slice arithmetic.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 1;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;
  localparam int unsigned REG_TP   = 4;
  localparam int unsigned REG_T0   = 5;
  localparam int unsigned REG_T1   = 6;
  localparam int unsigned REG_T2   = 7;
  localparam int unsigned REG_S0   = 8;
  localparam int unsigned REG_S1   = 9;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A1   = 11;
  localparam int unsigned REG_A2   = 12;
  localparam int unsigned REG_A3   = 13;
  localparam int unsigned REG_A4   = 14;
  localparam int unsigned REG_A5   = 15;
  localparam int unsigned REG_A6   = 16;
  localparam int unsigned REG_A7   = 17;
  localparam int unsigned REG_S2   = 18;
  localparam int unsigned REG_S3   = 19;
  localparam int unsigned REG_S4   = 20;
  localparam int unsigned REG_S5   = 21;
  localparam int unsigned REG_S6   = 22;
  localparam int unsigned REG_S7   = 23;
  localparam int unsigned REG_S8   = 24;
  localparam int unsigned REG_S9   = 25;
  localparam int unsigned REG_S10  = 26;
  localparam int unsigned REG_S11  = 27;
  localparam int unsigned REG_T3   = 28;
  localparam int unsigned REG_T4   = 29;
  localparam int unsigned REG_T5   = 30;
  localparam int unsigned REG_T6   = 31;

  // Low bit of port idx inside a flat vector of width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register valid scoreboard: flush > invalidate > writeback priority,
// plus read-side valid lookup with same-cycle writeback set-bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWB   = 1,
  parameter int unsigned NINV  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWB-1:0]    wb_en,
  input  logic [NWB*AW-1:0] wb_addr,
  input  logic [NINV-1:0]   inv_en,
  input  logic [NINV*AW-1:0] inv_addr,
  output logic [NRD-1:0]    rd_valid_c
);

  logic [NREGS-1:0] valid_q;
  logic [NREGS-1:0] valid_d;
  logic [NREGS-1:0] wb_hit_c;
  logic [NREGS-1:0] inv_hit_c;

  // Decode writeback and invalidate ports into per-register hit vectors.
  always_comb begin
    wb_hit_c  = '0;
    inv_hit_c = '0;
    for (int unsigned j = 0; j < NWB; j++) begin
      if (wb_en[j]) wb_hit_c[wb_addr[slice_lo(j, AW) +: AW]] = 1'b1;
    end
    for (int unsigned k = 0; k < NINV; k++) begin
      if (inv_en[k]) inv_hit_c[inv_addr[slice_lo(k, AW) +: AW]] = 1'b1;
    end
  end

  // An invalidate supersedes an older producer writing back in the same cycle.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (flush)             valid_d[r] = 1'b1;
      else if (inv_hit_c[r]) valid_d[r] = 1'b0;
      else if (wb_hit_c[r])  valid_d[r] = 1'b1;
    end
    valid_d[0] = 1'b1;
  end

  // Reads observe the pre-update valid, so a=a+imm sees its own source ready.
  always_comb begin
    rd_valid_c = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_valid_c[i] = valid_q[rd_addr[slice_lo(i, AW) +: AW]]
                    | wb_hit_c[rd_addr[slice_lo(i, AW) +: AW]]
                    | (rd_addr[slice_lo(i, AW) +: AW] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '1;
    else       valid_q <= valid_d;
  end

endmodule

// File: rtl/arch_regfile_mp.sv
// Multi-port integer architectural register file with write-to-read bypass,
// hardwired x0, valid scoreboard and a registered-operand stall indication.
module arch_regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWB   = 1,
  parameter int unsigned NINV  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_valid,
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*AW-1:0]    wb_addr,
  input  logic [NWB*XLEN-1:0]  wb_data,
  input  logic [NINV-1:0]      inv_en,
  input  logic [NINV*AW-1:0]   inv_addr,
  input  logic                 flush,
  output logic                 src_not_ready
);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NRD*XLEN-1:0] byp_data_c;
  logic [NRD-1:0]      sb_valid_c;
  logic [NRD-1:0]      rd_en_q;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD),
    .NWB   (NWB),
    .NINV  (NINV)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .inv_en     (inv_en),
    .inv_addr   (inv_addr),
    .rd_valid_c (sb_valid_c)
  );

  // Storage: ascending port order makes the highest-index writer win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWB; j++) begin
        if (wb_en[j] && (wb_addr[slice_lo(j, AW) +: AW] != '0)) begin
          regs_q[wb_addr[slice_lo(j, AW) +: AW]] <= wb_data[slice_lo(j, XLEN) +: XLEN];
        end
      end
    end
  end

  // Read bypass mirrors the storage priority; x0 always reads as zero.
  always_comb begin
    byp_data_c = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      byp_data_c[slice_lo(i, XLEN) +: XLEN] = regs_q[rd_addr[slice_lo(i, AW) +: AW]];
      for (int unsigned j = 0; j < NWB; j++) begin
        if (wb_en[j] && (wb_addr[slice_lo(j, AW) +: AW] == rd_addr[slice_lo(i, AW) +: AW])) begin
          byp_data_c[slice_lo(i, XLEN) +: XLEN] = wb_data[slice_lo(j, XLEN) +: XLEN];
        end
      end
      if (rd_addr[slice_lo(i, AW) +: AW] == '0) byp_data_c[slice_lo(i, XLEN) +: XLEN] = '0;
    end
  end

  // Read flops: data holds on idle ports, valid drops to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= '0;
      rd_en_q  <= '0;
    end else begin
      rd_en_q <= rd_en;
      for (int unsigned i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data[slice_lo(i, XLEN) +: XLEN] <= byp_data_c[slice_lo(i, XLEN) +: XLEN];
          rd_valid[i] <= sb_valid_c[i];
        end else begin
          rd_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign src_not_ready = |(rd_en_q & ~rd_valid);

endmodule

// File: tb/tb_arch_regfile_mp.sv
// Directed bench for arch_regfile_mp (two read, two writeback, one invalidate port).
module tb_arch_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWB   = 2;
  localparam int unsigned NINV  = 1;

  logic                clk;
  logic                reset;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_valid;
  logic [NWB-1:0]      wb_en;
  logic [NWB*AW-1:0]   wb_addr;
  logic [NWB*XLEN-1:0] wb_data;
  logic [NINV-1:0]     inv_en;
  logic [NINV*AW-1:0]  inv_addr;
  logic                flush;
  logic                src_not_ready;

  int errors = 0;
  int checks = 0;

  arch_regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWB   (NWB),
    .NINV  (NINV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .inv_en        (inv_en),
    .inv_addr      (inv_addr),
    .flush         (flush),
    .src_not_ready (src_not_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] ed0, ed1;
    logic [1:0]  ev;
    logic        es;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] re, input int unsigned ra0, input int unsigned ra1,
                     input logic [1:0] we, input int unsigned wa0, input logic [31:0] wd0,
                     input int unsigned wa1, input logic [31:0] wd1,
                     input logic ie, input int unsigned ia, input logic fl,
                     input logic [31:0] ed0, input logic [31:0] ed1,
                     input logic [1:0] ev, input logic es);
    vec_t v;
    v.re = re;  v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
    v.we = we;  v.wa0 = 5'(wa0); v.wd0 = wd0; v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.ie = ie;  v.ia = 5'(ia);   v.fl = fl;
    v.ed0 = ed0; v.ed1 = ed1; v.ev = ev; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rd_en    = v.re;
    rd_addr  = {v.ra1, v.ra0};
    wb_en    = v.we;
    wb_addr  = {v.wa1, v.wa0};
    wb_data  = {v.wd1, v.wd0};
    inv_en   = v.ie;
    inv_addr = v.ia;
    flush    = v.fl;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ed0, input logic [31:0] ed1,
                            input logic [1:0] ev, input logic es);
    check({tag, " rd_data0"}, rd_data[31:0], ed0);
    check({tag, " rd_data1"}, rd_data[63:32], ed1);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(ev));
    check({tag, " src_not_ready"}, 32'(src_not_ready), 32'(es));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t idle_v;
  vec_t hv;

  initial begin
    idle_v = '{default: '0};
    drive(idle_v);
    reset = 1'b1;
    repeat (2) cycle();
    check_outs("reset", 32'h0, 32'h0, 2'b00, 1'b0);
    reset = 1'b0;

    //   re     ra0      ra1     we     wa0      wd0            wa1     wd1        ie    ia       fl    ed0            ed1            ev     es
    add(2'b11, REG_A0,   REG_SP, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h0,         32'h0,         2'b11, 1'b0);
    add(2'b01, REG_A0,   0,      2'b01, REG_A0,  32'hDEADBEEF,  0,      32'h0,     1'b0, 0,       1'b0, 32'hDEADBEEF,  32'h0,         2'b01, 1'b0);
    add(2'b00, 0,        0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'hDEADBEEF,  32'h0,         2'b00, 1'b0);
    add(2'b10, 0,        REG_A0, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'hDEADBEEF,  32'hDEADBEEF,  2'b10, 1'b0);
    add(2'b00, 0,        0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b1, REG_T0,  1'b0, 32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 1'b0);
    add(2'b01, REG_T0,   0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h0,         32'hDEADBEEF,  2'b00, 1'b1);
    add(2'b01, REG_T0,   0,      2'b01, REG_T0,  32'h7,         0,      32'h0,     1'b0, 0,       1'b0, 32'h7,         32'hDEADBEEF,  2'b01, 1'b0);
    add(2'b00, 0,        0,      2'b01, REG_S1,  32'h12345678,  0,      32'h0,     1'b1, REG_S1,  1'b0, 32'h7,         32'hDEADBEEF,  2'b00, 1'b0);
    add(2'b11, REG_S1,   REG_S1, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h12345678,  32'h12345678,  2'b00, 1'b1);
    add(2'b01, REG_ZERO, 0,      2'b01, REG_ZERO,32'h5,         0,      32'h0,     1'b1, REG_ZERO,1'b0, 32'h0,         32'h12345678,  2'b01, 1'b0);
    add(2'b11, REG_ZERO, REG_ZERO,2'b00,0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h0,         32'h0,         2'b11, 1'b0);
    add(2'b00, 0,        0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b1, REG_A1,  1'b0, 32'h0,         32'h0,         2'b00, 1'b0);
    add(2'b00, 0,        0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b1, REG_A2,  1'b0, 32'h0,         32'h0,         2'b00, 1'b0);
    add(2'b01, REG_A1,   0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b1, REG_A3,  1'b0, 32'h0,         32'h0,         2'b00, 1'b1);
    add(2'b11, REG_A2,   REG_A3, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b1, 32'h0,         32'h0,         2'b00, 1'b1);
    add(2'b11, REG_A1,   REG_A3, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h0,         32'h0,         2'b11, 1'b0);
    add(2'b01, REG_A2,   0,      2'b11, REG_A2,  32'h1,         REG_A2, 32'h2,     1'b0, 0,       1'b0, 32'h2,         32'h0,         2'b01, 1'b0);
    add(2'b10, 0,        REG_A2, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h2,         32'h2,         2'b10, 1'b0);
    add(2'b01, REG_S0,   0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b1, REG_S0,  1'b0, 32'h0,         32'h2,         2'b01, 1'b0);
    add(2'b01, REG_S0,   0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h0,         32'h2,         2'b00, 1'b1);
    add(2'b01, REG_S0,   0,      2'b01, REG_S0,  32'hCAFE,      0,      32'h0,     1'b0, 0,       1'b0, 32'hCAFE,      32'h2,         2'b01, 1'b0);
    add(2'b00, 0,        0,      2'b10, 0,       32'h0,         REG_GP, 32'h55,    1'b0, 0,       1'b0, 32'hCAFE,      32'h2,         2'b00, 1'b0);
    add(2'b10, 0,        REG_GP, 2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'hCAFE,      32'h55,        2'b10, 1'b0);
    add(2'b00, 0,        0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b1, REG_A4,  1'b1, 32'hCAFE,      32'h55,        2'b00, 1'b0);
    add(2'b01, REG_A4,   0,      2'b00, 0,       32'h0,         0,      32'h0,     1'b0, 0,       1'b0, 32'h0,         32'h55,        2'b01, 1'b0);

    foreach (vecs[n]) begin
      drive(vecs[n]);
      cycle();
      check_outs($sformatf("vec%0d", n), vecs[n].ed0, vecs[n].ed1, vecs[n].ev, vecs[n].es);
    end

    // Mid-sequence reset: build up non-zero outputs first.
    hv = idle_v; hv.ie = 1'b1; hv.ia = 5'(REG_T1);
    drive(hv); cycle();
    hv = idle_v; hv.re = 2'b11; hv.ra0 = 5'(REG_T1); hv.ra1 = 5'(REG_A0);
    drive(hv); cycle();
    check_outs("pre_reset", 32'h0, 32'hDEADBEEF, 2'b10, 1'b1);

    hv = idle_v; hv.re = 2'b11; hv.ra0 = 5'(REG_T1); hv.ra1 = 5'(REG_A0);
    hv.we = 2'b01; hv.wa0 = 5'(REG_SP); hv.wd0 = 32'h99;
    hv.ie = 1'b1; hv.ia = 5'(REG_RA);
    drive(hv);
    reset = 1'b1;
    cycle();
    check_outs("mid_reset", 32'h0, 32'h0, 2'b00, 1'b0);
    reset = 1'b0;

    hv = idle_v; hv.re = 2'b11; hv.ra0 = 5'(REG_T1); hv.ra1 = 5'(REG_SP);
    drive(hv); cycle();
    check_outs("post_reset_t1_sp", 32'h0, 32'h0, 2'b11, 1'b0);
    hv = idle_v; hv.re = 2'b11; hv.ra0 = 5'(REG_A0); hv.ra1 = 5'(REG_RA);
    drive(hv); cycle();
    check_outs("post_reset_a0_ra", 32'h0, 32'h0, 2'b11, 1'b0);

    drive(idle_v);
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arch_regfile_mp.md
Name: arch_regfile_mp

Overview:
- Parametrised multi-port integer architectural register file with a per-register valid scoreboard.
- Supports NRD registered read ports, NWB writeback ports and NINV invalidation ports.
- Provides write-to-read bypass, a hardwired zero register, a pipeline flush of the scoreboard, and a source-not-ready stall signal to the decoder.
- Sits between decode/issue (reads, destination invalidation) and writeback (writes, valid set).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two.
- AW, $clog2(NREGS), register address width; derived, not overridden.
- NRD, 2, number of read ports.
- NWB, 1, number of writeback ports.
- NINV, 1, number of invalidation ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data.
- rd_valid  out  NRD  registered valid bit of the operand read.
- wb_en  in  NWB  per-port write enable.
- wb_addr  in  NWB*AW  write addresses.
- wb_data  in  NWB*XLEN  write data.
- inv_en  in  NINV  per-port invalidate enable (destination of issuing instruction).
- inv_addr  in  NINV*AW  invalidate addresses.
- flush  in  1  set every valid bit (squash in-flight producers).
- src_not_ready  out  1  any enabled read from the previous cycle returned an invalid operand.

Behaviour:
- Reset: all registers 0, all valid bits 1, rd_data 0, rd_valid 0, internal rd_en_q 0, src_not_ready 0. Reset overrides every other input in the same cycle.
- Read latency is 1 cycle. At the posedge with rd_en[i]=1:
  - rd_data[i] <= bypassed value; rd_valid[i] <= V[addr] OR any wb hit on addr.
  - A wb hit means wb_en[j] and wb_addr[j]==rd_addr[i]; the bypassed value is wb_data[j], otherwise the stored register.
- With rd_en[i]=0: rd_data[i] holds; rd_valid[i] <= 0.
- Multiple wb ports writing the same address in one cycle: the highest index j wins, for both storage and bypass.
- Register 0:
  - Reads return 0 with rd_valid=1.
  - Writes are discarded and do not bypass.
  - Invalidation of address 0 is ignored.
- Scoreboard update per cycle (next-state priority, high to low):
  - flush=1 -> all V <= 1.
  - inv hit on addr -> V[addr] <= 0. Invalidation beats a same-cycle writeback to the same address, because that writeback is from an older producer being superseded.
  - wb hit on addr -> V[addr] <= 1.
  - otherwise hold.
- Same-cycle read and invalidate of the same address: the read sees the pre-invalidate valid (rd_valid=1 if it was valid). This supports a=a+imm.
- Register storage writes occur regardless of flush or invalidate.
- src_not_ready = OR over i of (rd_en_q[i] AND NOT rd_valid[i]). It is combinational from flops, with no combinational path from inputs.
- A flush in cycle N does not alter rd_valid captured in cycle N; it takes effect for reads in cycle N+1.

Decomposition:
- Package regfile_pkg:
  - ABI register index constants (zero, ra, sp, gp, tp, t0-t6, s0-s11, a0-a7).
  - Default XLEN/NREGS.
  - Function for packed-slice indexing.
- Sub-module regfile_scoreboard (NREGS, AW, NRD, NWB, NINV):
  - Owns the valid array, the flush/invalidate/writeback priority, and the per-port read valid lookup with wb set-bypass.
- The top level holds data storage, the read flops and the stall logic.

Test Plan:
- Reset, then read a0 (10) and sp (2) on ports 0/1 -> next cycle rd_data=0/0, rd_valid=1/1, src_not_ready=0.
- Write wb a0=32'hDEAD_BEEF while reading a0 on port 0 in the same cycle -> next cycle rd_data[0]=DEADBEEF, rd_valid[0]=1; a read two cycles later also returns DEADBEEF.
- Invalidate t0 (5) in cycle N, read t0 in N+1 -> rd_valid[0]=0, src_not_ready=1 in N+2. Write t0=7 in N+2 with the read held -> N+3 rd_data=7, rd_valid=1, src_not_ready=0.
- Same-cycle inv_addr=s1 and wb_addr=s1 -> V[s1]=0 (a later read gives rd_valid=0), yet the stored s1 equals wb_data.
- Write x0=5 and invalidate x0, then read x0 -> rd_data=0, rd_valid=1. Invalidate a1..a3 over three cycles, then flush=1 -> reads of a1..a3 next cycle return rd_valid=1.
- NWB=2: both ports write a2 (wb0=1, wb1=2) in one cycle -> stored a2=2, and a same-cycle read bypass returns 2. Assert reset mid-sequence -> all outputs return to their reset values on the next edge.
